// File: rtl/tb_pkg.sv
// Shared trace-buffer types.
//   trace_rec_t : one retirement record, MSB first.
//   REC_W       : packed width of trace_rec_t.
//   MAX_NRET    : widest supported retire group (the lane field is 2 bits).
// The record layout is fixed at 32-bit XLEN and 32-bit cycle stamps; instantiating
// modules must keep their XLEN/CYC_W parameters equal to PKG_XLEN/PKG_CYC_W.
package tb_pkg;

    localparam int unsigned MAX_NRET  = 4;
    localparam int unsigned PKG_XLEN  = 32;
    localparam int unsigned PKG_CYC_W = 32;

    typedef struct packed {
        logic [PKG_CYC_W-1:0] cycle;
        logic [1:0]           lane;
        logic                 trap;
        logic [PKG_XLEN-1:0]  pc;
        logic [31:0]          insn;
        logic                 rd_we;
        logic                 rd_fp;
        logic [4:0]           rd_idx;
        logic [PKG_XLEN-1:0]  rd_wdata;
        logic                 csr_we;
        logic [11:0]          csr_addr;
        logic [PKG_XLEN-1:0]  csr_wdata;
    } trace_rec_t;

    localparam int unsigned REC_W = $bits(trace_rec_t);

endpackage

// File: rtl/trace_mwfifo.sv
// Multi-write, single-read first-word-fall-through FIFO.
//   push_cnt_i/push_data_i : up to NRET compacted entries (slot 0 first) offered per cycle.
//   push_ok_o              : the whole group fits; otherwise nothing is written.
//   pop_i                  : consume head (ignored when empty).
//   rd_data_o              : head entry, zero while empty.
//   level_o/full_o/empty_o : occupancy status.
// A pop in the same cycle frees one extra slot for the incoming group.
module trace_mwfifo #(
    parameter int unsigned NRET  = 2,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned W     = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [$clog2(NRET+1)-1:0]    push_cnt_i,
    input  logic [NRET-1:0][W-1:0]       push_data_i,
    output logic                         push_ok_o,
    input  logic                         pop_i,
    output logic [W-1:0]                 rd_data_o,
    output logic [$clog2(DEPTH):0]       level_o,
    output logic                         full_o,
    output logic                         empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [LW-1:0] level_q;
    logic [LW-1:0] free;
    logic [LW-1:0] push_n;
    logic          pop;

    assign empty_o   = (level_q == '0);
    assign full_o    = (level_q == LW'(DEPTH));
    assign level_o   = level_q;
    assign pop       = pop_i && !empty_o;
    assign free      = LW'(DEPTH) - level_q + LW'(pop);
    assign push_ok_o = (LW'(push_cnt_i) <= free);
    assign push_n    = push_ok_o ? LW'(push_cnt_i) : '0;
    assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            wr_ptr_q <= wr_ptr_q + AW'(push_n);
            level_q  <= level_q + push_n - LW'(pop);
        end
    end

    // Storage needs no reset: stale slots are never visible past the pointers.
    always_ff @(posedge clk_i) begin
        for (int j = 0; j < NRET; j++) begin
            if (push_ok_o && (int'(push_cnt_i) > j)) begin
                mem_q[wr_ptr_q + AW'(j)] <= push_data_i[j];
            end
        end
    end

endmodule

// File: rtl/rvvi_trace_buffer.sv
// Multi-retire trace capture buffer.
//   clk_i, rst_i (sync, active high)
//   enable_i, trap_only_i    : capture controls
//   ret_*_i                  : NRET retire lanes, lane i in bits [i*W +: W]
//   out_valid_o/out_ready_i  : record stream, out_rec_o is the head record
//   level_o/full_o/empty_o   : buffer occupancy
//   drop_cnt_o               : records lost to overflow (saturating)
//   cycle_o                  : free-running cycle stamp
// Qualifying lanes are stamped, compacted in lane order and written as one group;
// a group that does not fit is dropped whole.
module rvvi_trace_buffer
    import tb_pkg::*;
#(
    parameter int unsigned NRET  = 2,
    parameter int unsigned XLEN  = PKG_XLEN,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CYC_W = PKG_CYC_W
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    enable_i,
    input  logic                    trap_only_i,
    input  logic [NRET-1:0]         ret_valid_i,
    input  logic [NRET*XLEN-1:0]    ret_pc_i,
    input  logic [NRET*32-1:0]      ret_insn_i,
    input  logic [NRET-1:0]         ret_trap_i,
    input  logic [NRET-1:0]         ret_rd_we_i,
    input  logic [NRET-1:0]         ret_rd_fp_i,
    input  logic [NRET*5-1:0]       ret_rd_idx_i,
    input  logic [NRET*XLEN-1:0]    ret_rd_wdata_i,
    input  logic [NRET-1:0]         ret_csr_we_i,
    input  logic [NRET*12-1:0]      ret_csr_addr_i,
    input  logic [NRET*XLEN-1:0]    ret_csr_wdata_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output trace_rec_t              out_rec_o,
    output logic [$clog2(DEPTH):0]  level_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [31:0]             drop_cnt_o,
    output logic [CYC_W-1:0]        cycle_o
);

    localparam int unsigned CW = $clog2(NRET + 1);

    logic [CYC_W-1:0]             cycle_q;
    logic [31:0]                  drop_q;
    logic [32:0]                  drop_sum;
    logic [NRET-1:0]              qual;
    trace_rec_t                   lane_rec [NRET];
    logic [NRET-1:0][REC_W-1:0]   push_data;
    logic [CW-1:0]                push_cnt;
    logic                         push_ok;
    logic [REC_W-1:0]             head;
    logic                         pop;

    assign qual = ret_valid_i & {NRET{enable_i}} & (ret_trap_i | {NRET{~trap_only_i}});

    always_comb begin
        for (int i = 0; i < NRET; i++) begin
            lane_rec[i]           = '0;
            lane_rec[i].cycle     = cycle_q;
            lane_rec[i].lane      = 2'(i);
            lane_rec[i].trap      = ret_trap_i[i];
            lane_rec[i].pc        = ret_pc_i[i*XLEN +: XLEN];
            lane_rec[i].insn      = ret_insn_i[i*32 +: 32];
            lane_rec[i].rd_we     = ret_rd_we_i[i];
            lane_rec[i].rd_fp     = ret_rd_fp_i[i];
            lane_rec[i].rd_idx    = ret_rd_idx_i[i*5 +: 5];
            lane_rec[i].rd_wdata  = ret_rd_wdata_i[i*XLEN +: XLEN];
            lane_rec[i].csr_we    = ret_csr_we_i[i];
            lane_rec[i].csr_addr  = ret_csr_addr_i[i*12 +: 12];
            lane_rec[i].csr_wdata = ret_csr_wdata_i[i*XLEN +: XLEN];
        end
    end

    // Compaction: the n-th qualifying lane (ascending) lands in slot n.
    always_comb begin
        int cnt;
        cnt = 0;
        for (int j = 0; j < NRET; j++) begin
            push_data[j] = '0;
        end
        for (int i = 0; i < NRET; i++) begin
            if (qual[i]) begin
                for (int j = 0; j < NRET; j++) begin
                    if (j == cnt) begin
                        push_data[j] = lane_rec[i];
                    end
                end
                cnt = cnt + 1;
            end
        end
        push_cnt = CW'(cnt);
    end

    assign pop = out_valid_o && out_ready_i;

    trace_mwfifo #(
        .NRET  (NRET),
        .DEPTH (DEPTH),
        .W     (REC_W)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_cnt_i  (push_cnt),
        .push_data_i (push_data),
        .push_ok_o   (push_ok),
        .pop_i       (pop),
        .rd_data_o   (head),
        .level_o     (level_o),
        .full_o      (full_o),
        .empty_o     (empty_o)
    );

    assign out_valid_o = !empty_o;
    assign out_rec_o   = head;
    assign drop_sum    = {1'b0, drop_q} + 33'(push_cnt);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cycle_q <= '0;
            drop_q  <= '0;
        end else begin
            cycle_q <= cycle_q + 1'b1;
            if ((push_cnt != '0) && !push_ok) begin
                drop_q <= drop_sum[32] ? '1 : drop_sum[31:0];
            end
        end
    end

    assign cycle_o    = cycle_q;
    assign drop_cnt_o = drop_q;

endmodule

// File: doc/rvvi_trace_buffer.md
Name: rvvi_trace_buffer

Overview:
- Parametrised multi-retire trace capture block; successor to the single-hart, single-retire negedge tracer.
- Samples up to NRET retirement records per cycle from the core's RVVI-style retire ports.
- Stamps each record with a free-running cycle count and buffers records in a multi-write FIFO.
- Drains one record per cycle over a valid/ready stream to a file writer, checker or scoreboard.
- Adds trap-only filtering, atomic overflow drop with a drop counter, and backpressure, none of which the current tracer has.

Parameters:
- NRET, 2: retire lanes per cycle. Legal range 1..4.
- XLEN, 32: width of PC, GPR/FPR write data and CSR write data.
- DEPTH, 16: FIFO entries. Must be a power of 2 and must be >= NRET.
- CYC_W, 32: cycle-stamp width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- enable_i  in  1  capture enable. Draining continues while it is 0.
- trap_only_i  in  1  when 1, capture only lanes with trap set.
- ret_valid_i  in  NRET  per-lane retire valid.
- ret_pc_i  in  NRET*XLEN  per-lane PC.
- ret_insn_i  in  NRET*32  per-lane instruction word.
- ret_trap_i  in  NRET  per-lane trap flag.
- ret_rd_we_i  in  NRET  per-lane register write flag.
- ret_rd_fp_i  in  NRET  per-lane register-file select (1 = f-reg, 0 = x-reg).
- ret_rd_idx_i  in  NRET*5  per-lane destination register index.
- ret_rd_wdata_i  in  NRET*XLEN  per-lane register write data.
- ret_csr_we_i  in  NRET  per-lane CSR write flag.
- ret_csr_addr_i  in  NRET*12  per-lane CSR address.
- ret_csr_wdata_i  in  NRET*XLEN  per-lane CSR write data.
- out_valid_o  out  1  head record valid.
- out_ready_i  in  1  consumer ready.
- out_rec_o  out  REC_W  head record (trace_rec_t).
- level_o  out  $clog2(DEPTH)+1  occupancy.
- full_o  out  1  level_o == DEPTH.
- empty_o  out  1  level_o == 0.
- drop_cnt_o  out  32  records dropped on overflow.
- cycle_o  out  CYC_W  current cycle count.

Behaviour:
- Reset values: cycle_o=0, level_o=0, empty_o=1, full_o=0, out_valid_o=0, drop_cnt_o=0, read/write pointers=0, out_rec_o=0. Reset asserted mid-stream discards all buffered records.
- cycle_o increments by 1 every non-reset cycle and wraps modulo 2^CYC_W.
- Lane qualification: lane i qualifies when ret_valid_i[i] && enable_i && (!trap_only_i || ret_trap_i[i]). k = number of qualifying lanes.
- Record fields for each qualifying lane: cycle stamp = cycle_o value in that same cycle; lane index = i; all other fields copied from lane i.
- Free space: free = DEPTH - level_o, plus 1 if a pop occurs in the same cycle.
- Enqueue when k <= free: write qualifying records in ascending lane order into slots wr_ptr .. wr_ptr+k-1 (mod DEPTH), then wr_ptr += k.
- Overflow when k > free: drop all k records of that cycle atomically; no partial group is ever written. drop_cnt_o += k, saturating at 2^32-1.
- Dequeue: pop occurs when out_valid_o && out_ready_i. Then rd_ptr += 1 (mod DEPTH) and level_o decrements.
- Output (first-word fall-through): out_valid_o = !empty_o. out_rec_o = entry at rd_ptr and must be held stable while out_valid_o && !out_ready_i.
- Latency: a record captured in cycle t, with the FIFO empty, appears on the output in cycle t+1.
- Simultaneous push and pop: level_o(next) = level_o + k_written - pop.
- k = 0 in any cycle changes neither FIFO nor drop_cnt_o.
- Pointers use $clog2(DEPTH) bits and wrap naturally.

Decomposition:
- Shared package tb_pkg holds:
  - trace_rec_t packed struct, MSB first: cycle[CYC_W], lane[2], trap, pc[XLEN], insn[32], rd_we, rd_fp, rd_idx[5], rd_wdata[XLEN], csr_we, csr_addr[12], csr_wdata[XLEN].
  - REC_W localparam.
  - MAX_NRET = 4.
- Sub-module trace_mwfifo: generic multi-write (up to NRET pushes), single-read FIFO carrying the push-count and free-space logic.
- Top level holds lane qualification, lane compaction, cycle counter and drop counter.

Test Plan:
- Reset, then lane0 only: pc=0x80000000, insn=0x00500093, rd x1=5 in cycle 3 -> cycle 4: out_valid_o=1, record cycle=3, lane=0, rd_idx=1, rd_wdata=5; level_o=1.
- Both lanes valid in one cycle with out_ready_i=0 -> two records in lane order 0 then 1, both with the same cycle stamp; level_o=2.
- DEPTH=16, out_ready_i=0, level_o=15, two lanes valid -> both dropped, drop_cnt_o=2, level_o stays 15. Same case with out_ready_i=1 -> both written (free = 2), level_o=16, full_o=1.
- trap_only_i=1, lane0 trap=0, lane1 trap=1 (mcause CSR write 0x2) -> exactly one record: lane=1, csr_addr=0x342, csr_wdata=2.
- Random backpressure over 1000 retires -> output sequence equals the qualifying input sequence in order, with no loss while drop_cnt_o=0. Pointer wrap exercised at least 60 times.
- Assert rst_i with level_o=7 -> next cycle level_o=0, out_valid_o=0, cycle_o=0, drop_cnt_o=0.
